// File: rtl/fetch_pc_reg.sv
// Program-counter register and IF/ID pipeline latch for the fetch stage.
// Optional saturating performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_reg #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] next_pc,
    input  logic [WIDTH-1:0] instr_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] npc_out,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_npc,
    output logic             ifid_valid,
    output logic             fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    logic [WIDTH-1:0] pc;
    logic             pc_load;
    logic             misaligned;

    // Sequential address wraps modulo 2^WIDTH; no overflow flag exists.
    assign npc_out    = pc + WIDTH'(PC_STEP);
    assign pc_out     = pc;
    assign pc_load    = flush || !stall;
    assign misaligned = |next_pc[1:0];

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list;
    // all state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ifid_instr  <= '0;
            ifid_npc    <= '0;
            ifid_valid  <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (flush) begin
            // Taken branch: redirect PC and squash the wrong-path instruction.
            pc          <= {next_pc[WIDTH-1:2], 2'b00};
            ifid_instr  <= '0;
            ifid_npc    <= '0;
            ifid_valid  <= 1'b0;
            fetch_fault <= misaligned;
        end else if (stall) begin
            fetch_fault <= 1'b0;
        end else begin
            pc          <= {next_pc[WIDTH-1:2], 2'b00};
            ifid_instr  <= instr_in;
            ifid_npc    <= npc_out;
            ifid_valid  <= 1'b1;
            fetch_fault <= misaligned;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_event;
    logic stall_event;

    assign fetch_event = pc_load && !flush;
    assign stall_event = stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_event && (perf_fetch_cnt != 32'hFFFF_FFFF))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_event && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_reg.sv
// Self-checking bench for fetch_pc_reg: directed scenarios plus randomized
// traffic against a behavioural model of the fetch stage.
module tb_fetch_pc_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] next_pc, instr_in;
    logic [31:0] pc_out, npc_out, ifid_instr, ifid_npc;
    logic        ifid_valid, fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [31:0] m_pc, m_instr, m_npc;
    logic        m_valid, m_fault;
    longint      m_fetches, m_stalls;

    always #5 clk = ~clk;

    fetch_pc_reg dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .instr_in    (instr_in),
        .stall       (stall),
        .flush       (flush),
        .pc_out      (pc_out),
        .npc_out     (npc_out),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
        .fetch_fault (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Model of one clock edge, stated directly from the fetch-stage rules.
    task automatic model_edge();
        longint unsigned seq;
        seq = (longint'(m_pc) + 4) % 64'h1_0000_0000;
        if (rst) begin
            m_pc = 32'h0; m_instr = 0; m_npc = 0; m_valid = 0; m_fault = 0;
            m_fetches = 0; m_stalls = 0;
        end else if (flush) begin
            m_fault = (next_pc % 4) != 0;
            m_pc = next_pc - (next_pc % 4);
            m_instr = 0; m_npc = 0; m_valid = 0;
        end else if (stall) begin
            m_fault = 0;
            if (m_stalls < 64'hFFFF_FFFF) m_stalls++;
        end else begin
            m_fault = (next_pc % 4) != 0;
            m_npc = seq[31:0];
            m_instr = instr_in;
            m_valid = 1;
            m_pc = next_pc - (next_pc % 4);
            if (m_fetches < 64'hFFFF_FFFF) m_fetches++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; stall = 0; flush = 0; next_pc = 32'h40; instr_in = 32'hDEAD_BEEF;
        tick();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
        checks++; if (npc_out !== 32'h4) begin errors++; $display("FAIL reset_npc got %h exp %h", npc_out, 32'h4); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", ifid_instr); end
        checks++; if (ifid_npc !== 32'h0) begin errors++; $display("FAIL reset_ifid_npc got %h exp 0", ifid_npc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fetch_fault); end
        rst = 0;
    endtask

    task automatic test_sequential();
        next_pc = 32'h4; instr_in = 32'hAAAA_AAAA;
        tick();
        checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL seq1_pc got %h exp 4", pc_out); end
        checks++; if (ifid_instr !== 32'hAAAA_AAAA) begin errors++; $display("FAIL seq1_instr got %h exp aaaaaaaa", ifid_instr); end
        checks++; if (ifid_npc !== 32'h4) begin errors++; $display("FAIL seq1_ifid_npc got %h exp 4", ifid_npc); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got %b exp 1", ifid_valid); end
        next_pc = 32'h8; instr_in = 32'h5555_5555;
        tick();
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL seq2_pc got %h exp 8", pc_out); end
        checks++; if (npc_out !== 32'hC) begin errors++; $display("FAIL seq2_npc got %h exp c", npc_out); end
        checks++; if (ifid_instr !== 32'h5555_5555) begin errors++; $display("FAIL seq2_instr got %h exp 55555555", ifid_instr); end
        checks++; if (ifid_npc !== 32'h8) begin errors++; $display("FAIL seq2_ifid_npc got %h exp 8", ifid_npc); end
    endtask

    task automatic test_stall();
        stall = 1; next_pc = 32'h100; instr_in = $urandom;
        tick();
        instr_in = $urandom;
        tick();
        checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL stall_pc got %h exp 8", pc_out); end
        checks++; if (ifid_instr !== 32'h5555_5555) begin errors++; $display("FAIL stall_instr got %h exp 55555555", ifid_instr); end
        checks++; if (ifid_npc !== 32'h8) begin errors++; $display("FAIL stall_ifid_npc got %h exp 8", ifid_npc); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", ifid_valid); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stall_cnt !== 32'd2) begin errors++; $display("FAIL stall_cnt got %0d exp 2", perf_stall_cnt); end
        checks++; if (perf_fetch_cnt !== 32'd2) begin errors++; $display("FAIL fetch_cnt got %0d exp 2", perf_fetch_cnt); end
`endif
    endtask

    task automatic test_flush_stall();
        stall = 1; flush = 1; next_pc = 32'hA5A5_A5A4; instr_in = 32'h1234_5678;
        tick();
        checks++; if (pc_out !== 32'hA5A5_A5A4) begin errors++; $display("FAIL flush_pc got %h exp a5a5a5a4", pc_out); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL flush_instr got %h exp 0", ifid_instr); end
        checks++; if (ifid_npc !== 32'h0) begin errors++; $display("FAIL flush_ifid_npc got %h exp 0", ifid_npc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL flush_fault got %b exp 0", fetch_fault); end
        stall = 0; flush = 0;
    endtask

    task automatic test_misalign_wrap();
        next_pc = 32'hFFFF_FFFF; instr_in = 32'hCAFE_F00D;
        tick();
        checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", pc_out); end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL wrap_fault got %b exp 1", fetch_fault); end
        checks++; if (npc_out !== 32'h0) begin errors++; $display("FAIL wrap_npc got %h exp 0", npc_out); end
        checks++; if (ifid_npc !== 32'hA5A5_A5A8) begin errors++; $display("FAIL wrap_ifid_npc got %h exp a5a5a5a8", ifid_npc); end
        next_pc = 32'h0; instr_in = 32'h0BAD_CAFE;
        tick();
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL wrap_fault_clear got %b exp 0", fetch_fault); end
        checks++; if (ifid_npc !== 32'h0) begin errors++; $display("FAIL wrap_ifid_npc2 got %h exp 0", ifid_npc); end
        checks++; if (ifid_instr !== 32'h0BAD_CAFE) begin errors++; $display("FAIL wrap_instr got %h exp 0badcafe", ifid_instr); end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1; rst = 1; next_pc = 32'h200; instr_in = 32'h1111_1111;
        tick();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_stall_pc got %h exp 0", pc_out); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_valid got %b exp 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_stall_instr got %h exp 0", ifid_instr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_stall_cnt got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        rst = 0; stall = 0; next_pc = 32'h4; instr_in = 32'h2222_2222;
        tick();
        checks++; if (ifid_instr !== 32'h2222_2222 || ifid_valid !== 1'b1 || ifid_npc !== 32'h4) begin
            errors++; $display("FAIL rst_first_fetch got %h/%b/%h exp 22222222/1/4", ifid_instr, ifid_valid, ifid_npc);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_npc;
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(99, 0) < 3);
            flush    = ($urandom_range(99, 0) < 15);
            stall    = ($urandom_range(99, 0) < 25);
            next_pc  = ($urandom_range(3, 0) == 0) ? $urandom : (m_pc + 32'd4);
            instr_in = $urandom;
            tick();
            exp_npc = m_pc + 32'd4;
            checks++;
            if (pc_out !== m_pc || npc_out !== exp_npc || ifid_instr !== m_instr ||
                ifid_npc !== m_npc || ifid_valid !== m_valid || fetch_fault !== m_fault) begin
                errors++;
                $display("FAIL rand[%0d] got pc=%h npc=%h ins=%h inpc=%h v=%b f=%b exp pc=%h npc=%h ins=%h inpc=%h v=%b f=%b",
                         i, pc_out, npc_out, ifid_instr, ifid_npc, ifid_valid, fetch_fault,
                         m_pc, exp_npc, m_instr, m_npc, m_valid, m_fault);
            end
`ifdef FETCH_PERF_CNT_EN
            checks++;
            if (perf_fetch_cnt !== m_fetches[31:0] || perf_stall_cnt !== m_stalls[31:0]) begin
                errors++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", i, perf_fetch_cnt, perf_stall_cnt,
                         m_fetches, m_stalls);
            end
`endif
        end
        rst = 0; flush = 0; stall = 0;
    endtask

    initial begin
        m_pc = 0; m_instr = 0; m_npc = 0; m_valid = 0; m_fault = 0;
        m_fetches = 0; m_stalls = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush_stall();
        test_misalign_wrap();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_reg.md
# fetch_pc_reg

Program-counter register and IF/ID pipeline latch for the instruction-fetch stage. Consumes the 32-bit next-PC selected by the upstream PC-source mux (sequential vs. branch target), presents the fetch address to instruction memory, and produces PC+4 back to that mux's sequential input. Latches the fetched instruction and its PC+4 into the IF/ID register with stall and flush control for the decode stage.

## Interface

- WIDTH, 32, datapath/address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment in bytes

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- next_pc  input  WIDTH  PC selected by upstream mux (mux y)
- instr_in  input  WIDTH  instruction word read combinationally from memory at pc_out
- stall  input  1  hold PC and IF/ID (hazard unit)
- flush  input  1  squash IF/ID contents (taken branch)
- pc_out  output  WIDTH  current fetch address
- npc_out  output  WIDTH  pc_out + PC_STEP, combinational, to mux sequential input
- ifid_instr  output  WIDTH  latched instruction
- ifid_npc  output  WIDTH  latched PC+PC_STEP of that instruction
- ifid_valid  output  1  IF/ID holds a real instruction
- fetch_fault  output  1  one-cycle pulse: misaligned next_pc was loaded
- perf_fetch_cnt  output  32  valid fetches (only with FETCH_PERF_CNT_EN)
- perf_stall_cnt  output  32  stalled cycles (only with FETCH_PERF_CNT_EN)

One clock; reset is synchronous and active-high.

## Operation

- Per-edge priority: rst > flush > stall > normal.
- rst: pc_out = RESET_PC; ifid_instr = 0; ifid_npc = 0; ifid_valid = 0; fetch_fault = 0; counters = 0.
- normal: pc <= {next_pc[WIDTH-1:2], 2'b00}; ifid_instr <= instr_in; ifid_npc <= pc + PC_STEP; ifid_valid <= 1.
- stall (flush low): pc, ifid_instr, ifid_npc, ifid_valid all hold; fetch_fault <= 0.
- flush: bubble inserted — ifid_instr <= 0 (NOP), ifid_npc <= 0, ifid_valid <= 0; pc loads next_pc as in normal (redirect). Flush with stall: flush wins, PC loads.
- fetch_fault <= 1 for one cycle when PC loads (normal or flush) and next_pc[1:0] != 0; otherwise 0. Low bits are forced to 00 regardless.
- npc_out arithmetic modulo 2^WIDTH: pc 32'hFFFF_FFFC gives npc_out 32'h0000_0000, no flag.
- No state machine beyond the registers; the block is a single-stage pipeline register with enable (stall) and synchronous clear (flush).

## Timing

- next_pc -> pc_out: 1 cycle.
- pc_out -> ifid_instr/ifid_npc: 1 cycle (instruction memory read is combinational within the cycle).
- npc_out tracks pc_out with zero cycle latency.
- stall/flush sampled at the same edge they act on; a flush asserted for N cycles yields N bubbles.
- Reset mid-stream discards IF/ID contents; first fetch after release is at RESET_PC, its instruction valid in IF/ID one edge after rst deasserts.
- fetch_fault is registered, visible the cycle after the faulting load.

## Configuration

- FETCH_PERF_CNT_EN defined: perf_fetch_cnt increments on each edge loading ifid_valid=1; perf_stall_cnt increments on each edge with stall=1, flush=0, rst=0. Both saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: both counters and their ports are absent; all other behaviour identical.

## Test plan

- Reset: rst=1 one edge, RESET_PC=0 -> pc_out=0, npc_out=4, ifid_valid=0, ifid_instr=0, fetch_fault=0.
- Sequential: next_pc tied to npc_out, instr_in=32'hAAAA_AAAA then 32'h5555_5555 -> pc_out 0,4,8; ifid_npc 4 then 8 with matching instructions, ifid_valid=1.
- Stall: pc_out=8, stall=1 for 2 cycles -> pc_out stays 8, IF/ID unchanged; perf_stall_cnt +2 with macro.
- Flush+stall: next_pc=32'hA5A5_A5A4, flush=1, stall=1 -> pc_out=32'hA5A5_A5A4, ifid_valid=0, ifid_instr=0.
- Misalign/wrap: next_pc=32'hFFFF_FFFF -> pc_out=32'hFFFF_FFFC, fetch_fault pulses one cycle, npc_out=0.
- Reset mid-stall: stall=1 and rst=1 together -> pc_out=RESET_PC, ifid_valid=0, counters 0.
